// File: rtl/audio_out_fifo.sv
// Stereo sample FIFO between the averaging filter and the codec write port; primes before playback.
// Define AUDIO_OUT_REPEAT_EN to re-send the last popped sample on underrun cycles instead of starving the codec.
module audio_out_fifo #(
   parameter int DATA_WIDTH  = 24,
   parameter int DEPTH       = 8,
   parameter int PRIME_LEVEL = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic [DATA_WIDTH-1:0]      in_left,
   input  logic [DATA_WIDTH-1:0]      in_right,
   output logic                       in_ready,
   input  logic                       write_ready,
   output logic                       write,
   output logic [DATA_WIDTH-1:0]      writedata_left,
   output logic [DATA_WIDTH-1:0]      writedata_right,
   output logic [$clog2(DEPTH):0]     level,
   output logic [15:0]                underrun_count,
   output logic                       overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int PW = 2 * DATA_WIDTH;

   typedef enum logic {
      PRIME = 1'b0,
      RUN   = 1'b1
   } state_t;

   state_t            state_r;
   logic [PW-1:0]     mem_r [DEPTH];
   logic [AW-1:0]     wr_ptr_r;
   logic [AW-1:0]     rd_ptr_r;
   logic [LW-1:0]     level_r;
   logic [PW-1:0]     hold_r;
   logic [15:0]       underrun_r;
   logic              overflow_r;

   logic              full_s;
   logic              empty_s;
   logic              push_s;
   logic              drop_s;
   logic              pop_s;
   logic              underrun_s;
   logic              write_s;
   logic [PW-1:0]     head_s;
   logic [PW-1:0]     data_s;

   // Handshake decode: push/drop on the filter side, pop/underrun on the codec side.
   always_comb begin
      full_s     = (level_r == LW'(DEPTH));
      empty_s    = (level_r == {LW{1'b0}});
      head_s     = mem_r[rd_ptr_r];
      push_s     = in_valid && !full_s;
      drop_s     = in_valid && full_s;
      underrun_s = 1'b0;
      write_s    = 1'b0;
      data_s     = hold_r;
      if (state_r == RUN) begin
         underrun_s = write_ready && empty_s;
`ifdef AUDIO_OUT_REPEAT_EN
         write_s    = write_ready;
`else
         write_s    = write_ready && !empty_s;
`endif
         if (!empty_s) begin
            data_s = head_s;
         end else begin
            data_s = hold_r;
         end
      end else begin
         underrun_s = 1'b0;
         write_s    = 1'b0;
         data_s     = hold_r;
      end
      // A repeated write on an underrun cycle never consumes an entry.
      pop_s = write_s && write_ready && !empty_s;
   end

   // Sample storage; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (!reset && push_s) begin
         mem_r[wr_ptr_r] <= {in_left, in_right};
      end
   end

   // Pointers, fill level, hold register, status counters and priming state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= PRIME;
         wr_ptr_r   <= {AW{1'b0}};
         rd_ptr_r   <= {AW{1'b0}};
         level_r    <= {LW{1'b0}};
         hold_r     <= {PW{1'b0}};
         underrun_r <= 16'h0000;
         overflow_r <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
            hold_r   <= head_s;
         end
         case ({push_s, pop_s})
            2'b10:   level_r <= level_r + LW'(1);
            2'b01:   level_r <= level_r - LW'(1);
            default: level_r <= level_r;
         endcase
         if (drop_s) begin
            overflow_r <= 1'b1;
         end
         if (underrun_s && (underrun_r != 16'hFFFF)) begin
            underrun_r <= underrun_r + 16'd1;
         end
         case (state_r)
            PRIME:   if (level_r >= LW'(PRIME_LEVEL)) state_r <= RUN;
            RUN:     if (underrun_s) state_r <= PRIME;
            default: state_r <= PRIME;
         endcase
      end
   end

   assign in_ready        = !full_s;
   assign write           = write_s;
   assign writedata_left  = data_s[PW-1:DATA_WIDTH];
   assign writedata_right = data_s[DATA_WIDTH-1:0];
   assign level           = level_r;
   assign underrun_count  = underrun_r;
   assign overflow        = overflow_r;

endmodule
